// File: rtl/jtkcpu_stack_pkg.sv
// ============================================================================
// Module  : jtkcpu_stack_pkg
// Purpose : Shared CPU constants: CC bit positions, stack FSM states and the
//           default wide-slot mask.
// Revision: 1.0
// ============================================================================
`default_nettype none

package jtkcpu_stack_pkg;

    localparam int unsigned c_CC_C = 0;
    localparam int unsigned c_CC_V = 1;
    localparam int unsigned c_CC_Z = 2;
    localparam int unsigned c_CC_N = 3;
    localparam int unsigned c_CC_I = 4;
    localparam int unsigned c_CC_H = 5;
    localparam int unsigned c_CC_F = 6;
    localparam int unsigned c_CC_E = 7;

    // Slots 4..7 (X, Y, U/S, PC) are 16-bit; slots 0..3 (CC, A, B, DP) are 8-bit
    localparam logic [7:0] c_WIDE_DEFAULT = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NEXT = 2'd1,
        ST_XFER = 2'd2,
        ST_FIN  = 2'd3
    } stack_state_t;

endpackage

`default_nettype wire

// File: rtl/jtkcpu_stack_pick.sv
// ============================================================================
// Module  : jtkcpu_stack_pick
// Purpose : Priority encoder: highest set bit for push, lowest for pull.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtkcpu_stack_pick
    import jtkcpu_stack_pkg::*;
(
    input  logic [7:0] mask_i,
    input  logic       pull_i,
    output logic [2:0] idx_o,
    output logic       valid_o
);

    always_comb begin
        idx_o   = 3'd0;
        valid_o = |mask_i;
        if (pull_i) begin
            for (int i = 7; i >= 0; i--) begin
                if (mask_i[i]) idx_o = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mask_i[i]) idx_o = 3'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/jtkcpu_stack.sv
// ============================================================================
// Module  : jtkcpu_stack
// Purpose : Push/pull sequencer moving selected registers over a byte bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jtkcpu_stack
    import jtkcpu_stack_pkg::*;
#(
    parameter int         NREG = 8,
    parameter logic [7:0] WIDE = c_WIDE_DEFAULT,
    parameter int         AW   = 16
) (
    input  logic               rst_i,
    input  logic               clk_i,
    input  logic               cen_i,
    input  logic               start_i,
    input  logic               pull_i,
    input  logic [NREG-1:0]    sel_i,
    input  logic [AW-1:0]      sp_in_i,
    input  logic [16*NREG-1:0] regs_i,
    input  logic               ack_i,
    input  logic [7:0]         din_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [AW-1:0]      addr_o,
    output logic [7:0]         dout_o,
    output logic               we_o,
    output logic               rd_o,
    output logic               wr_en_o,
    output logic [2:0]         wr_idx_o,
    output logic               wr_hi_o,
    output logic [7:0]         wr_data_o,
    output logic [AW-1:0]      sp_out_o,
    output logic               sp_upd_o
);

    stack_state_t       state_q, state_d;
    logic               pull_q, pull_d;
    logic [7:0]         mask_q, mask_d;
    logic [16*NREG-1:0] regs_q, regs_d;
    logic [AW-1:0]      sp_q, sp_d;
    logic [2:0]         idx_q, idx_d;
    logic               hi_q, hi_d;
    logic               pend_q, pend_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [7:0]         dout_q, dout_d;
    logic               we_q, we_d;
    logic               rd_q, rd_d;
    logic               wr_en_q, wr_en_d;
    logic [2:0]         wr_idx_q, wr_idx_d;
    logic               wr_hi_q, wr_hi_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic [AW-1:0]      sp_out_q, sp_out_d;

    logic [15:0] w_slot [8];
    logic [2:0]  w_pick_idx;
    logic        w_pick_valid;
    logic [2:0]  w_cur_idx;
    logic        w_cur_wide;
    logic        w_cur_hi;
    logic [15:0] w_slot_cur;
    logic [7:0]  w_cur_byte;

    for (genvar gi = 0; gi < 8; gi++) begin : g_slot
        if (gi < NREG) begin : g_used
            assign w_slot[gi] = regs_q[16*gi +: 16];
        end else begin : g_unused
            assign w_slot[gi] = 16'h0000;
        end
    end

    jtkcpu_stack_pick u_pick (
        .mask_i  (mask_q),
        .pull_i  (pull_q),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_valid)
    );

    // A pending second byte reuses the slot; its half is the opposite of the first
    assign w_cur_idx  = pend_q ? idx_q : w_pick_idx;
    assign w_cur_wide = WIDE[w_cur_idx];
    assign w_cur_hi   = pend_q ? ~pull_q : (w_cur_wide & pull_q);
    assign w_slot_cur = w_slot[w_cur_idx];
    assign w_cur_byte = w_cur_hi ? w_slot_cur[15:8] : w_slot_cur[7:0];

    always_comb begin
        state_d   = state_q;
        pull_d    = pull_q;
        mask_d    = mask_q;
        regs_d    = regs_q;
        sp_d      = sp_q;
        idx_d     = idx_q;
        hi_d      = hi_q;
        pend_d    = pend_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        we_d      = we_q;
        rd_d      = rd_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_hi_d   = wr_hi_q;
        wr_data_d = wr_data_q;
        sp_out_d  = sp_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    pull_d  = pull_i;
                    mask_d  = 8'(sel_i);
                    sp_d    = sp_in_i;
                    regs_d  = regs_i;
                    pend_d  = 1'b0;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (pend_q || w_pick_valid) begin
                    idx_d  = w_cur_idx;
                    hi_d   = w_cur_hi;
                    pend_d = ~pend_q & w_cur_wide;
                    if (!pend_q) mask_d[w_cur_idx] = 1'b0;
                    if (pull_q) begin
                        addr_d = sp_q;
                        sp_d   = sp_q + AW'(1);
                        rd_d   = 1'b1;
                    end else begin
                        addr_d = sp_q - AW'(1);
                        sp_d   = sp_q - AW'(1);
                        dout_d = w_cur_byte;
                        we_d   = 1'b1;
                    end
                    state_d = ST_XFER;
                end else begin
                    sp_out_d = sp_q;
                    state_d  = ST_FIN;
                end
            end
            ST_XFER: begin
                if (ack_i) begin
                    we_d    = 1'b0;
                    rd_d    = 1'b0;
                    state_d = ST_NEXT;
                    if (pull_q) begin
                        wr_en_d   = 1'b1;
                        wr_idx_d  = idx_q;
                        wr_hi_d   = hi_q;
                        wr_data_d = din_i;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pull_q    <= 1'b0;
            mask_q    <= '0;
            regs_q    <= '0;
            sp_q      <= '0;
            idx_q     <= '0;
            hi_q      <= 1'b0;
            pend_q    <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_hi_q   <= 1'b0;
            wr_data_q <= '0;
            sp_out_q  <= '0;
        end else if (cen_i) begin
            state_q   <= state_d;
            pull_q    <= pull_d;
            mask_q    <= mask_d;
            regs_q    <= regs_d;
            sp_q      <= sp_d;
            idx_q     <= idx_d;
            hi_q      <= hi_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_hi_q   <= wr_hi_d;
            wr_data_q <= wr_data_d;
            sp_out_q  <= sp_out_d;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_FIN);
    assign sp_upd_o  = (state_q == ST_FIN);
    assign addr_o    = addr_q;
    assign dout_o    = dout_q;
    assign we_o      = we_q;
    assign rd_o      = rd_q;
    assign wr_en_o   = wr_en_q;
    assign wr_idx_o  = wr_idx_q;
    assign wr_hi_o   = wr_hi_q;
    assign wr_data_o = wr_data_q;
    assign sp_out_o  = sp_out_q;

endmodule

`default_nettype wire

// File: tb/tb_jtkcpu_stack.sv
// ============================================================================
// Module  : tb_jtkcpu_stack
// Purpose : Directed self-checking bench with a transaction-level stack model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jtkcpu_stack;

    localparam int         NREG = 8;
    localparam int         AW   = 16;
    localparam logic [7:0] WIDE = 8'hF0;

    typedef struct { logic [15:0] addr; logic [7:0] data; logic wr; } bus_t;
    typedef struct { logic [2:0] idx; logic hi; logic [7:0] data; } wb_t;

    logic         clk = 1'b0;
    logic         rst, cen, start, pull, ack;
    logic [7:0]   sel;
    logic [15:0]  sp_in;
    logic [127:0] regs;
    logic [7:0]   din;
    logic         busy, done, we, rd, wr_en, wr_hi, sp_upd;
    logic [15:0]  addr, sp_out;
    logic [7:0]   dout, wr_data;
    logic [2:0]   wr_idx;

    logic [7:0] mem [0:65535];
    bus_t exp_bus[$];
    wb_t  exp_wb[$];
    wb_t  wb_log[$];

    int checks = 0, failures = 0;
    int exp_lat, cen_edges, byte_num, stalls, done_count, last_lat;
    int wait_byte = 0, wait_n = 0;
    logic [15:0] exp_sp, last_sp;
    logic in_seq = 1'b0, prev_done = 1'b0, prev_cen = 1'b0, hold_valid = 1'b0, cen_rand = 1'b0;
    logic [25:0] hold;
    logic [69:0] all_out;

    always #5 clk = ~clk;

    assign din = mem[addr];
    assign all_out = {busy, done, we, rd, wr_en, sp_upd, addr, dout, wr_idx, wr_hi, wr_data, sp_out};

    jtkcpu_stack #(.NREG(NREG), .WIDE(WIDE), .AW(AW)) dut (
        .rst_i(rst), .clk_i(clk), .cen_i(cen), .start_i(start), .pull_i(pull),
        .sel_i(sel), .sp_in_i(sp_in), .regs_i(regs), .ack_i(ack), .din_i(din),
        .busy_o(busy), .done_o(done), .addr_o(addr), .dout_o(dout), .we_o(we),
        .rd_o(rd), .wr_en_o(wr_en), .wr_idx_o(wr_idx), .wr_hi_o(wr_hi),
        .wr_data_o(wr_data), .sp_out_o(sp_out), .sp_upd_o(sp_upd)
    );

    // Expected bus traffic, register write-backs, final pointer and latency
    task automatic build_model(input logic p, input logic [7:0] s, input logic [15:0] sp,
                               input logic [127:0] r, input int wb_byte, input int wn);
        logic [15:0] ptr;
        logic [15:0] v;
        logic [7:0]  wide_v;
        bus_t b;
        wb_t  w;
        int   nb;
        ptr = sp; nb = 0; wide_v = WIDE;
        exp_bus.delete(); exp_wb.delete();
        if (!p) begin
            for (int i = NREG-1; i >= 0; i--) begin
                if (s[i]) begin
                    v = r[16*i +: 16];
                    ptr = ptr - 16'd1; b.addr = ptr; b.data = v[7:0]; b.wr = 1'b1;
                    exp_bus.push_back(b); nb++;
                    if (wide_v[i]) begin
                        ptr = ptr - 16'd1; b.addr = ptr; b.data = v[15:8];
                        exp_bus.push_back(b); nb++;
                    end
                end
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (s[i]) begin
                    w.idx = 3'(i);
                    if (wide_v[i]) begin
                        b.addr = ptr; b.data = mem[ptr]; b.wr = 1'b0; exp_bus.push_back(b);
                        w.hi = 1'b1; w.data = mem[ptr]; exp_wb.push_back(w);
                        ptr = ptr + 16'd1; nb++;
                    end
                    b.addr = ptr; b.data = mem[ptr]; b.wr = 1'b0; exp_bus.push_back(b);
                    w.hi = 1'b0; w.data = mem[ptr]; exp_wb.push_back(w);
                    ptr = ptr + 16'd1; nb++;
                end
            end
        end
        exp_sp  = ptr;
        exp_lat = 2*nb + 2 + ((wb_byte >= 1 && wb_byte <= nb) ? wn : 0);
    endtask

    // cen and ack drivers
    initial begin
        ack = 1'b1; cen = 1'b1;
        forever begin
            @(posedge clk); #2;
            cen = cen_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            ack = !((we || rd) && (byte_num + 1 == wait_byte) && (stalls < wait_n));
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                checks++;
                if (all_out !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", all_out); end
                exp_bus.delete(); exp_wb.delete();
                in_seq = 1'b0; hold_valid = 1'b0; prev_done = 1'b0; prev_cen = 1'b0;
            end else begin
                checks++;
                if (we && rd) begin failures++; $display("FAIL we_rd_both: got we=%b rd=%b want not both", we, rd); end
                checks++;
                if ((we || rd) && !busy) begin failures++; $display("FAIL strobe_idle: got we=%b rd=%b busy=0", we, rd); end
                if (hold_valid) begin
                    checks++;
                    if ({addr, dout, we, rd} !== hold) begin
                        failures++; $display("FAIL wait_stable: got %h want %h", {addr, dout, we, rd}, hold);
                    end
                end
                hold_valid = 1'b0;
                if ((we || rd) && !(ack && cen)) begin
                    hold = {addr, dout, we, rd}; hold_valid = 1'b1;
                    if (!ack) stalls++;
                end
                if (wr_en) begin
                    wb_t e, g;
                    g.idx = wr_idx; g.hi = wr_hi; g.data = wr_data;
                    wb_log.push_back(g);
                    checks++;
                    if (exp_wb.size() == 0) begin
                        failures++; $display("FAIL wb_extra: got idx=%0d hi=%b data=%h want none", wr_idx, wr_hi, wr_data);
                    end else begin
                        e = exp_wb.pop_front();
                        if (g.idx !== e.idx || g.hi !== e.hi || g.data !== e.data) begin
                            failures++;
                            $display("FAIL wb: got idx=%0d hi=%b data=%h want idx=%0d hi=%b data=%h",
                                     g.idx, g.hi, g.data, e.idx, e.hi, e.data);
                        end
                    end
                end
                if ((we || rd) && ack && cen) begin
                    bus_t e;
                    checks++;
                    if (exp_bus.size() == 0) begin
                        failures++; $display("FAIL bus_extra: got addr=%h we=%b want none", addr, we);
                    end else begin
                        e = exp_bus.pop_front();
                        if (addr !== e.addr || we !== e.wr || rd !== !e.wr || (e.wr && dout !== e.data)) begin
                            failures++;
                            $display("FAIL bus: got addr=%h dout=%h we=%b rd=%b want addr=%h dout=%h we=%b",
                                     addr, dout, we, rd, e.addr, e.data, e.wr);
                        end
                    end
                    if (we) mem[addr] = dout;
                    byte_num++;
                end
                if (prev_done && prev_cen) begin
                    checks++;
                    if (done) begin failures++; $display("FAIL done_width: got done=1 want 0"); end
                end
                if (in_seq) begin
                    checks++;
                    if (!busy) begin failures++; $display("FAIL busy: got 0 want 1"); end
                end
                if (done && !prev_done) begin
                    checks++;
                    if (!in_seq) begin
                        failures++; $display("FAIL done_unexpected: got done=1 want 0");
                    end else begin
                        if (cen_edges + 1 != exp_lat || sp_out !== exp_sp || !sp_upd ||
                            exp_bus.size() != 0 || exp_wb.size() != 0) begin
                            failures++;
                            $display("FAIL done: got lat=%0d sp=%h upd=%b left=%0d/%0d want lat=%0d sp=%h upd=1 left=0/0",
                                     cen_edges + 1, sp_out, sp_upd, exp_bus.size(), exp_wb.size(), exp_lat, exp_sp);
                        end
                        last_lat = cen_edges + 1; last_sp = sp_out;
                        done_count++; in_seq = 1'b0;
                    end
                end
                if (in_seq && cen) cen_edges++;
                if (start && cen && !busy) begin
                    in_seq = 1'b1; cen_edges = 0; byte_num = 0; stalls = 0;
                end
                prev_done = done; prev_cen = cen;
            end
        end
    end

    task automatic run_seq(input logic p, input logic [7:0] s, input logic [15:0] sp,
                           input logic [127:0] r, input int wb_byte, input int wn);
        int t, d0;
        build_model(p, s, sp, r, wb_byte, wn);
        wait_byte = wb_byte; wait_n = wn;
        d0 = done_count;
        @(posedge clk); #3;
        start = 1'b1; pull = p; sel = s; sp_in = sp; regs = r; cen = 1'b1;
        @(posedge clk); #3;
        start = 1'b0; pull = 1'($urandom); sel = 8'($urandom); sp_in = 16'($urandom);
        regs = {$urandom, $urandom, $urandom, $urandom};
        t = 0;
        while (done_count == d0 && t < 300) begin @(posedge clk); t++; end
        if (done_count == d0) begin
            checks++; failures++; $display("FAIL timeout: got no done want done");
        end
        repeat (2) @(posedge clk);
        wait_byte = 0;
    endtask

    task automatic lit(input logic ok, input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (!ok) begin failures++; $display("FAIL %s: got %h want %h", name, got, want); end
    endtask

    logic [127:0] r24, r7, recon;
    int t, d0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        rst = 1'b1; start = 1'b0; pull = 1'b0; sel = '0; sp_in = '0; regs = '0;
        done_count = 0; byte_num = 0; stalls = 0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);

        r24 = {16'h1234, 16'h6666, 16'h5555, 16'h4444, 16'h0033, 16'h0022, 16'h0011, 16'h005A};
        run_seq(1'b0, 8'h81, 16'h1000, r24, 0, 0);
        lit(mem[16'h0FFF] == 8'h34, "push_0FFF", 32'(mem[16'h0FFF]), 32'h34);
        lit(mem[16'h0FFE] == 8'h12, "push_0FFE", 32'(mem[16'h0FFE]), 32'h12);
        lit(mem[16'h0FFD] == 8'h5A, "push_0FFD", 32'(mem[16'h0FFD]), 32'h5A);
        lit(last_sp == 16'h0FFD, "push_sp", 32'(last_sp), 32'h0FFD);
        lit(last_lat == 8, "push_lat", 32'(last_lat), 32'd8);

        wb_log.delete();
        run_seq(1'b1, 8'h81, 16'h0FFD, '0, 0, 0);
        lit(wb_log.size() == 3, "pull_wb_count", 32'(wb_log.size()), 32'd3);
        if (wb_log.size() == 3) begin
            lit({wb_log[0].idx, wb_log[0].hi, wb_log[0].data} == 12'h05A, "pull_wb0",
                32'({wb_log[0].idx, wb_log[0].hi, wb_log[0].data}), 32'h05A);
            lit({wb_log[1].idx, wb_log[1].hi, wb_log[1].data} == 12'hF12, "pull_wb1",
                32'({wb_log[1].idx, wb_log[1].hi, wb_log[1].data}), 32'hF12);
            lit({wb_log[2].idx, wb_log[2].hi, wb_log[2].data} == 12'hE34, "pull_wb2",
                32'({wb_log[2].idx, wb_log[2].hi, wb_log[2].data}), 32'hE34);
        end
        lit(last_sp == 16'h1000, "pull_sp", 32'(last_sp), 32'h1000);

        run_seq(1'b0, 8'h00, 16'h4321, r24, 0, 0);
        lit(last_sp == 16'h4321, "empty_sp", 32'(last_sp), 32'h4321);
        lit(last_lat == 2, "empty_lat", 32'(last_lat), 32'd2);

        run_seq(1'b0, 8'h81, 16'h1000, r24, 2, 3);
        lit(last_lat == 11, "wait_lat", 32'(last_lat), 32'd11);

        run_seq(1'b0, 8'h01, 16'h0000, r24, 0, 0);
        lit(mem[16'hFFFF] == 8'h5A, "wrap_mem", 32'(mem[16'hFFFF]), 32'h5A);
        lit(last_sp == 16'hFFFF, "wrap_push_sp", 32'(last_sp), 32'hFFFF);
        run_seq(1'b1, 8'h01, 16'hFFFF, '0, 0, 0);
        lit(last_sp == 16'h0000, "wrap_pull_sp", 32'(last_sp), 32'h0000);

        r7 = {16'hF00D, 16'hBEEF, 16'hCAFE, 16'hD00D, 16'h0011, 16'h0022, 16'h0033, 16'h0044};
        run_seq(1'b0, 8'hFF, 16'h8000, r7, 4, 1);
        lit(last_sp == 16'h7FF4, "all_push_sp", 32'(last_sp), 32'h7FF4);
        wb_log.delete();
        run_seq(1'b1, 8'hFF, 16'h7FF4, '0, 7, 2);
        recon = '0;
        foreach (wb_log[i]) recon[16*wb_log[i].idx + (wb_log[i].hi ? 8 : 0) +: 8] = wb_log[i].data;
        lit(recon == r7, "all_roundtrip", recon[31:0], r7[31:0]);
        lit(last_sp == 16'h8000, "all_pull_sp", 32'(last_sp), 32'h8000);

        cen_rand = 1'b1;
        run_seq(1'b0, 8'h3C, 16'h2468, r7, 0, 0);
        cen_rand = 1'b0;
        run_seq(1'b1, 8'h5A, 16'h7FF6, '0, 1, 2);

        // Abort a push in its second byte with an asynchronous reset
        build_model(1'b0, 8'h81, 16'h2000, r24, 0, 0);
        @(posedge clk); #3;
        start = 1'b1; pull = 1'b0; sel = 8'h81; sp_in = 16'h2000; regs = r24; cen = 1'b1;
        @(posedge clk); #3 start = 1'b0;
        t = 0;
        while (!(byte_num == 1 && we) && t < 50) begin @(posedge clk); #3; t++; end
        lit(t < 50, "abort_reach", 32'(t), 32'd0);
        rst = 1'b1;
        #1 lit(all_out == '0, "abort_async", all_out[31:0], 32'h0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        d0 = done_count;
        repeat (10) @(posedge clk);
        lit(done_count == d0 && !busy, "abort_no_done", 32'(done_count - d0), 32'd0);
        run_seq(1'b0, 8'h81, 16'h2000, r24, 0, 0);
        lit(last_sp == 16'h1FFD, "after_abort_sp", 32'(last_sp), 32'h1FFD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jtkcpu_stack.md
JTKCPU_STACK -- requirements
Module: jtkcpu_stack

Interface
REQ-001 Parameter NREG, default 8: number of stackable register slots, 1..8; slot index equals sel bit position.
REQ-002 Parameter WIDE, default 8'hF0: bitmask marking 16-bit slots; other slots are 8-bit and use bits [7:0].
REQ-003 Parameter AW, default 16: stack pointer and address width.
REQ-004 Ports:
- rst  input  1  asynchronous active-high reset
- clk  input  1  single clock
- cen  input  1  clock enable; all state advances only when cen=1
- start  input  1  request a push or pull sequence
- pull  input  1  0=push, 1=pull; sampled with start
- sel  input  NREG  register mask
- sp_in  input  AW  stack pointer at start
- regs  input  16*NREG  flattened register values; slot i at [16i+15:16i]
- ack  input  1  memory ready for the current byte
- din  input  8  pulled memory byte
- busy  output  1  sequence in progress
- done  output  1  one-cen end pulse
- addr  output  AW  memory address
- dout  output  8  pushed byte
- we  output  1  write strobe
- rd  output  1  read strobe
- wr_en  output  1  register byte write pulse (pull)
- wr_idx  output  3  slot being written
- wr_hi  output  1  1=byte [15:8], 0=byte [7:0]
- wr_data  output  8  byte for the register file
- sp_out  output  AW  final stack pointer
- sp_upd  output  1  sp_out valid pulse, coincident with done

Function
REQ-005 FSM states: IDLE, NEXT (pick slot and byte), XFER (bus byte in flight), FIN.
REQ-006 IDLE: start=1 at cen latches pull, sel, sp_in and regs, then moves to NEXT; start is ignored outside IDLE.
REQ-007 Push order: highest set slot first; wide slot sends low byte then high byte; pointer is pre-decremented before each byte, so the high byte ends at the lower address.
REQ-008 Pull order: lowest set slot first; wide slot reads high byte then low byte; pointer is post-incremented after each byte.
REQ-009 NEXT takes one cen, then XFER; an all-zero remaining mask sends NEXT to FIN.
REQ-010 XFER holds addr, dout, we/rd stable until ack=1 at cen; each ack=0 cycle adds one wait cycle.
REQ-011 On pull, the accepting cen registers wr_en=1 for one cen, with wr_idx, wr_hi and wr_data=din.
REQ-012 FIN: done=1 and sp_upd=1 for exactly one cen; sp_out holds the final pointer until the next start; then IDLE.
REQ-013 With ack tied high, a sequence of B bytes accepted at cen k asserts done at cen k+2B+2; for B=0, done is at cen k+2.
REQ-014 busy=1 from the cen after acceptance through FIN inclusive.
REQ-015 Pointer arithmetic is modulo 2^AW; wrap in both directions is legal and unflagged.
REQ-016 Slots at index >= NREG are never generated; a narrow slot never produces a high-byte cycle.
REQ-017 we and rd are never both 1; both are 0 outside XFER.

Reset
REQ-018 rst=1 forces IDLE asynchronously, regardless of cen.
REQ-019 Under reset, every output is 0 (busy, done, we, rd, wr_en, sp_upd, addr, dout, wr_idx, wr_hi, wr_data, sp_out).
REQ-020 Reset during a sequence aborts it with no done pulse; no partial-state retention.

Structure
REQ-021 State encodings and WIDE default belong in the shared jtkcpu package/include alongside CC bit constants.
REQ-022 One sub-module, jtkcpu_stack_pick: combinational priority encoder returning the next slot index and a valid flag for a mask and a direction.
REQ-023 No memory arbitration inside; the block only drives the byte bus.

Verification
REQ-024 Push: sel=0x81, sp_in=0x1000, PC=0x1234, CC=0x5A, ack=1 -> writes 0x0FFF=0x34, 0x0FFE=0x12, 0x0FFD=0x5A; sp_out=0x0FFD; done at k+8.
REQ-025 Pull: sel=0x81, sp_in=0x0FFD, memory from REQ-024 -> wr_en (idx0,lo,0x5A), (idx7,hi,0x12), (idx7,lo,0x34); sp_out=0x1000.
REQ-026 Empty: sel=0x00 -> no we/rd; done at k+2; sp_out=sp_in.
REQ-027 Wait states: ack low 3 cens on byte 2 -> addr/dout/we stable throughout; done delayed by exactly 3 cens.
REQ-028 Wrap: push sel=0x01, sp_in=0x0000 -> addr 0xFFFF, sp_out=0xFFFF; pull from 0xFFFF -> sp_out=0x0000.
REQ-029 Reset at second XFER of a push -> all outputs 0 at once, no done; a new start after release runs normally.
